// File: rtl/multi_pulse_stretcher.sv
// Multi-channel pulse stretcher: each trigger on a[i] produces a len-cycle pulse on b[i],
// optionally retriggerable, with an optional cooldown window after each pulse.
module multi_pulse_stretcher #(
  parameter int CH     = 4,
  parameter int CW     = 4,
  parameter int GAP    = 2,
  parameter int RETRIG = 1,
  parameter int EDGE   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [CH-1:0] a,
  input  logic [CW-1:0] len,
  output logic [CH-1:0] b,
  output logic [CH-1:0] done,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, HOLD, COOL} state_t;

  localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

  logic [CH-1:0] a_prev_reg;
  logic [CH-1:0] trig;
  logic [CH-1:0] active_next;
  logic          len_ok;
  logic [CW-1:0] len_m1;
  logic          busy_reg;

  assign len_ok = |len;
  assign len_m1 = len - CW'(1);
  assign trig   = (EDGE != 0) ? (a & ~a_prev_reg) : a;
  assign busy   = busy_reg;

  // Edge history tracks a every cycle, independent of en and clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_prev_reg <= '0;
      busy_reg   <= 1'b0;
    end else begin
      a_prev_reg <= a;
      busy_reg   <= |active_next;
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      state_t        state_reg, state_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic          b_reg, b_next;
      logic          done_reg, done_next;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          b_reg     <= 1'b0;
          done_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          b_reg     <= b_next;
          done_reg  <= done_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        b_next     = b_reg;
        done_next  = 1'b0;
        if (clr) begin
          state_next = IDLE;
          cnt_next   = '0;
          b_next     = 1'b0;
        end else if (en) begin
          case (state_reg)
            IDLE: begin
              if (trig[gi] && len_ok) begin
                state_next = HOLD;
                cnt_next   = len_m1;
                b_next     = 1'b1;
              end
            end
            HOLD: begin
              // A reload on the terminal count wins, so the pulse stays unbroken.
              if ((RETRIG != 0) && trig[gi] && len_ok) begin
                cnt_next = len_m1;
                b_next   = 1'b1;
              end else if (cnt_reg != '0) begin
                cnt_next = cnt_reg - CW'(1);
              end else begin
                b_next    = 1'b0;
                done_next = 1'b1;
                if (GAP > 0) begin
                  state_next = COOL;
                  cnt_next   = GAP_LOAD;
                end else begin
                  state_next = IDLE;
                end
              end
            end
            COOL: begin
              if (cnt_reg != '0) cnt_next = cnt_reg - CW'(1);
              else               state_next = IDLE;
            end
            default: begin
              state_next = IDLE;
              cnt_next   = '0;
              b_next     = 1'b0;
            end
          endcase
        end
      end

      assign active_next[gi] = (state_next != IDLE);
      assign b[gi]           = b_reg;
      assign done[gi]        = done_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// Scoreboard bench: two stretcher configurations share random/directed stimulus and are
// compared cycle by cycle against a remaining-cycles reference model.
module tb_multi_pulse_stretcher;

  localparam int CH = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic          clr = 1'b0;
  logic [CH-1:0] a   = '0;
  logic [CW-1:0] len = '0;
  logic [CH-1:0] b0, d0, b1, d1;
  logic          busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults (GAP=2, retrigger, level). Instance 1: no cooldown, no retrigger, edge.
  multi_pulse_stretcher #(.CH(CH), .CW(CW)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .len(len),
    .b(b0), .done(d0), .busy(busy0)
  );
  multi_pulse_stretcher #(.CH(CH), .CW(CW), .GAP(0), .RETRIG(0), .EDGE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .len(len),
    .b(b1), .done(d1), .busy(busy1)
  );

  typedef struct packed {
    logic [1:0][CH-1:0] b;
    logic [1:0][CH-1:0] d;
    logic [1:0]         bz;
  } exp_t;

  exp_t exp_q[$];

  // Model state: cycles of b still to come, and cooldown cycles still to come.
  int            hold_left [2][CH];
  int            cool_left [2][CH];
  logic [CH-1:0] m_prev;
  int            retrig_p [2] = '{1, 0};
  int            edge_p   [2] = '{0, 1};
  int            gap_p    [2] = '{2, 0};

  task automatic check(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < CH; c++) begin
        hold_left[k][c] = 0;
        cool_left[k][c] = 0;
      end
    m_prev = '0;
  endtask

  task automatic model_step(input logic [CH-1:0] ai, input int li, input logic ei, input logic ci);
    exp_t e;
    logic t;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < CH; c++) begin
        t = (edge_p[k] != 0) ? (ai[c] & ~m_prev[c]) : ai[c];
        if (ci) begin
          hold_left[k][c] = 0;
          cool_left[k][c] = 0;
        end else if (ei) begin
          if (hold_left[k][c] > 0) begin
            if (retrig_p[k] != 0 && t && li != 0) begin
              hold_left[k][c] = li;
            end else begin
              hold_left[k][c]--;
              if (hold_left[k][c] == 0) begin
                e.d[k][c] = 1'b1;
                cool_left[k][c] = gap_p[k];
              end
            end
          end else if (cool_left[k][c] > 0) begin
            cool_left[k][c]--;
          end else if (t && li != 0) begin
            hold_left[k][c] = li;
          end
        end
        e.b[k][c] = (hold_left[k][c] > 0);
        if (hold_left[k][c] > 0 || cool_left[k][c] > 0) e.bz[k] = 1'b1;
      end
    end
    m_prev = ai;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [CH-1:0] ai, input int li, input logic ei, input logic ci);
    @(negedge clk);
    rst = 1'b1;
    a   = ai;
    len = li[CW-1:0];
    en  = ei;
    clr = ci;
    model_step(ai, li, ei, ci);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 3, 1'b1, 1'b0);
  endtask

  // Monitor: one comparison set per clock whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("b_cfg0",    b0,                       e.b[0]);
        check("done_cfg0", d0,                       e.d[0]);
        check("busy_cfg0", {{(CH-1){1'b0}}, busy0},  {{(CH-1){1'b0}}, e.bz[0]});
        check("b_cfg1",    b1,                       e.b[1]);
        check("done_cfg1", d1,                       e.d[1]);
        check("busy_cfg1", {{(CH-1){1'b0}}, busy1},  {{(CH-1){1'b0}}, e.bz[1]});
        $display("cyc t=%0t a=%h len=%0d en=%b clr=%b | b0=%h d0=%h bz0=%b | b1=%h d1=%h bz1=%b",
                 $time, a, len, en, clr, b0, d0, busy0, b1, d1, busy1);
      end
    end
  end

  initial begin
    logic [CH-1:0] ar;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_b0", b0, '0);
    check("reset_done0", d0, '0);
    check("reset_busy", {{(CH-2){1'b0}}, busy1, busy0}, '0);

    // Single pulse len=3, triggers during and after cooldown.
    drive(4'b0001, 3, 1, 0);
    idle(3);
    drive(4'b0001, 3, 1, 0);
    drive(4'b0001, 3, 1, 0);
    drive(4'b0001, 3, 1, 0);
    idle(6);
    // Retrigger len=5 at T and T+3; edges on a[1] at T and T+2, then held.
    drive(4'b0011, 5, 1, 0);
    drive(4'b0000, 5, 1, 0);
    drive(4'b0010, 5, 1, 0);
    drive(4'b0011, 5, 1, 0);
    for (int i = 0; i < 6; i++) drive(4'b0010, 5, 1, 0);
    drive(4'b0000, 5, 1, 0);
    drive(4'b0010, 5, 1, 0);
    idle(10);
    // len=0 and len=15 boundaries.
    drive(4'b0100, 0, 1, 0);
    idle(3);
    drive(4'b0100, 15, 1, 0);
    idle(20);
    // Freeze mid-hold for three cycles.
    drive(4'b1000, 6, 1, 0);
    idle(2);
    for (int i = 0; i < 3; i++) drive(4'b1000, 6, 0, 0);
    idle(10);
    // Clear mid-hold, overriding a simultaneous trigger.
    drive(4'b0001, 8, 1, 0);
    idle(2);
    drive(4'b0010, 8, 1, 1);
    idle(4);
    // All channels together with len=2.
    drive(4'b1111, 2, 1, 0);
    idle(6);

    // Asynchronous reset mid-hold clears outputs without waiting for a clock.
    drive(4'b0101, 9, 1, 0);
    idle(2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_b0", b0, '0);
    check("async_rst_b1", b1, '0);
    check("async_rst_done", d0 | d1, '0);
    check("async_rst_busy", {{(CH-2){1'b0}}, busy1, busy0}, '0);
    a = '0;
    model_reset();
    idle(2);

    // Randomized traffic with level holds, occasional freezes, clears and zero lengths.
    ar = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 3) == 0) ar[c] = ($urandom_range(0, 3) == 0);
      drive(ar,
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)),
            ($urandom_range(0, 15) != 0),
            ($urandom_range(0, 99) == 0));
    end
    idle(20);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_pulse_stretcher.md
Name: multi_pulse_stretcher

Overview:
- Parametrised, multi-channel pulse stretcher and hold timer.
- Each channel turns a trigger on `a[i]` into an output pulse on `b[i]` lasting a programmable number of cycles.
- Per-channel options: retrigger, edge/level trigger detect, and a post-pulse cooldown.
- Sits between event sources and downstream control logic. Replaces the fixed 4-cycle single-channel output/counter pair.

Parameters:
- CH, 4, number of independent channels.
- CW, 4, counter width in bits; the maximum hold length is 2^CW-1 cycles.
- GAP, 2, cooldown cycles after a pulse ends, during which triggers are ignored (0 = no cooldown).
- RETRIG, 1, 1 = a trigger during HOLD reloads the counter; 0 = triggers during HOLD are ignored.
- EDGE, 0, 0 = level trigger (`a[i]`==1); 1 = rising-edge trigger (`a[i]` is 1 now and was 0 on the previous clock).

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; 0 freezes all channels.
- clr  in  1  synchronous clear of all channels; takes priority over en.
- a  in  CH  per-channel trigger.
- len  in  CW  hold length in cycles, shared; sampled per channel on each accepted trigger.
- b  out  CH  stretched output pulse, registered.
- done  out  CH  one-cycle end-of-pulse strobe, registered.
- busy  out  1  registered OR of all channels not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - all channels go to IDLE, counter 0, edge-history register 0.
  - b=0, done=0, busy=0.
  - Mid-pulse reset aborts immediately with no done strobe.
- Channel state machine: IDLE -> HOLD -> COOL (only if GAP>0) -> IDLE.
- trig[i] definition: level mode is `a[i]`; edge mode is `a[i]` & ~`a_prev[i]`. `a_prev` updates every clock, regardless of en or clr.
- IDLE, trig, len!=0:
  - load cnt=len-1 and enter HOLD.
  - b[i] goes to 1 on that same edge (visible the cycle after trig is sampled).
- IDLE, trig, len==0: trigger dropped; stay in IDLE; no pulse and no done.
- HOLD, b[i]=1:
  - trig with RETRIG=1 and len!=0: reload cnt=len-1. b stays high for exactly len more cycles after that edge.
  - trig with RETRIG=1 and len==0: treated as no trigger.
  - No trig, or RETRIG=0: if cnt!=0, decrement cnt.
  - cnt==0 and no reload: b[i]=0 and done[i]=1 for one cycle. Then go to COOL with cnt=GAP-1 if GAP>0, else to IDLE.
  - Net result: the pulse width without retrigger is exactly len cycles.
- Retrigger on the same edge cnt reaches 0 (RETRIG=1): the reload wins, no done is generated, and b stays continuously high.
- Level mode with RETRIG=1: holding `a[i]` high keeps b[i] high indefinitely. done fires len cycles after `a[i]` falls (counting from the first edge where trig=0).
- COOL:
  - b=0 and triggers are ignored (not queued).
  - Decrement cnt; at cnt==0, go to IDLE on the next edge.
  - Minimum spacing from done to the next accepted trigger edge is GAP cycles.
- en=0: state, cnt and b hold. done forced 0. Triggers are lost (not latched).
- clr=1 (when rst=1): on the next edge, all channels go to IDLE, cnt=0, b=0, done=0; no done strobe is generated. clr overrides a simultaneous trig.
- busy: registered; equals 1 in any cycle where any channel is in HOLD or COOL.
- Channels are fully independent apart from the shared len, en and clr.
- Arithmetic: cnt is CW bits unsigned. len-1 is computed only when len!=0, so it never wraps.

Test Plan:
- Defaults; pulse `a[0]`=1 for one cycle at edge T with len=3:
  - b[0]=1 during cycles T+1..T+3.
  - done[0]=1 at T+4 only.
  - a trigger at T+4 or T+5 is ignored; a trigger at T+6 is accepted.
  - busy=1 over T+1..T+5.
- Retrigger, len=5: trigger at T, second trigger at T+3:
  - b[0] high continuously over T+1..T+8.
  - single done at T+9.
- RETRIG=0, EDGE=1, len=4: rising edges on `a[1]` at T and T+2:
  - b[1] high over T+1..T+4 only; the second edge has no effect.
  - `a[1]` held high afterwards produces no new pulse until it falls and rises again.
- len=0 trigger gives no b, done or busy activity. len=15 with CW=4 gives a pulse exactly 15 cycles wide.
- en=0 for 3 cycles mid-HOLD: the pulse lengthens by exactly 3 cycles, and done does not fire during the freeze.
- Abort checks, each starting mid-HOLD:
  - clr=1 for one cycle gives b=0 and busy=0 on the next edge, with no done.
  - Separately, rst low asynchronously clears b immediately.
  - Simultaneous triggers on all 4 channels with len=2 give identical b waveforms.
